mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, byte-addressed, word-wide memory between the fetch stage (IF port) and
//  the load/store stage (D port) of the pipelined core. Grants one request per cycle, routes the
//  1-cycle-latency read data back to the winning requester, and prevents fetch starvation.
//  Supports fetch flush on branch redirect. Sits between the IF/MEM stages and the unified memory.
// PARAMETERS
//  ADDRESS_WIDTH  8   memory byte-address bits actually decoded; upper address bits ignored (wrap)
//  DATA_WIDTH     32  word width of every data/address bus
//  MAX_WAIT       3   consecutive cycles IF may be refused before it gets forced priority (1..15)
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  rst_n        in   1   synchronous, active-low reset
//  if_req_i     in   1   fetch requests a word read
//  if_addr_i    in   32  fetch byte address (PC)
//  if_flush_i   in   1   discard any IF response still in flight (branch redirect)
//  if_gnt_o     out  1   IF request accepted this cycle
//  if_rvalid_o  out  1   IF read data valid
//  if_rdata_o   out  32  IF read data (instruction)
//  d_req_i      in   1   load/store requests access
//  d_we_i       in   1   1 = store, 0 = load
//  d_addr_i     in   32  load/store byte address
//  d_be_i       in   4   store byte enables (ignored for loads)
//  d_wdata_i    in   32  store data
//  d_gnt_o      out  1   D request accepted this cycle
//  d_rvalid_o   out  1   D response valid (load data, or store acknowledge)
//  d_rdata_o    out  32  load data; 0 on store acknowledge
//  mem_en_o     out  1   memory access this cycle
//  mem_we_o     out  1   memory write
//  mem_addr_o   out  ADDRESS_WIDTH  word-aligned byte address {addr[ADDRESS_WIDTH-1:2],2'b00}
//  mem_be_o     out  4   write byte enables (4'b0000 on reads)
//  mem_wdata_o  out  32  write data
//  mem_rdata_i  in   32  read data, valid exactly one cycle after mem_en_o && !mem_we_o
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all outputs 0, response-owner reg = NONE, wait counter = 0.
//  - Arbitration (combinational, same cycle): if only one req, it wins. Both req: D wins unless
//    wait_cnt >= MAX_WAIT, then IF wins. gnt_o and mem_* driven in the grant cycle; one gnt max.
//  - wait_cnt: +1 (saturating at 15) each cycle IF requests and loses; cleared when IF granted
//    or IF not requesting.
//  - Response: owner reg latches {IF, D_LOAD, D_STORE, NONE} at grant edge. Next cycle:
//    IF -> if_rvalid_o=1, if_rdata_o=mem_rdata_i; D_LOAD -> d_rvalid_o=1, d_rdata_o=mem_rdata_i;
//    D_STORE -> d_rvalid_o=1, d_rdata_o=0. Latency fixed at 1; back-to-back grants every cycle.
//  - rdata outputs are 0 whenever the matching rvalid is 0.
//  - Flush: if_flush_i=1 suppresses if_rvalid_o in that cycle for an in-flight IF response, and
//    blocks any IF grant in that cycle; D traffic unaffected. Flush with nothing in flight: no-op.
//  - Alignment: mem_addr_o low 2 bits forced 0; address bits >= ADDRESS_WIDTH dropped (wraps).
//  - Reset mid-transaction: in-flight response dropped, no rvalid in the cycle after reset.
//  - No requests: mem_en_o=0, mem_we_o=0, mem_be_o=0, owner -> NONE.
// TESTING
//  1. Reset, IF req addr 0x04 alone -> if_gnt_o=1, mem_addr_o=0x04; next cycle if_rvalid_o=1,
//     if_rdata_o=mem_rdata_i.
//  2. IF and D load both req every cycle, MAX_WAIT=3 -> D granted 3 cycles, IF granted on 4th,
//     pattern repeats; responses routed to correct port each cycle.
//  3. D store addr 0x13, be=4'b0011, wdata 0xDEADBEEF -> mem_we_o=1, mem_addr_o=0x10,
//     mem_be_o=4'b0011; next cycle d_rvalid_o=1, d_rdata_o=0.
//  4. IF granted, if_flush_i=1 next cycle -> if_rvalid_o=0, no IF grant that cycle.
//  5. IF addr 0x0000_0102 with ADDRESS_WIDTH=8 -> mem_addr_o=0x00.
//  6. rst_n=0 the cycle after a D load grant -> d_rvalid_o=0 following cycle, all outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port, word-wide memory between the fetch (IF) and
// load/store (D) stages. One grant per cycle, fixed 1-cycle read latency,
// bounded IF starvation and IF response flush on branch redirect.
module mem_port_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_WAIT      = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // fetch port
  input  logic                     if_req_i,
  input  logic [DATA_WIDTH-1:0]    if_addr_i,
  input  logic                     if_flush_i,
  output logic                     if_gnt_o,
  output logic                     if_rvalid_o,
  output logic [DATA_WIDTH-1:0]    if_rdata_o,
  // load/store port
  input  logic                     d_req_i,
  input  logic                     d_we_i,
  input  logic [DATA_WIDTH-1:0]    d_addr_i,
  input  logic [3:0]               d_be_i,
  input  logic [DATA_WIDTH-1:0]    d_wdata_i,
  output logic                     d_gnt_o,
  output logic                     d_rvalid_o,
  output logic [DATA_WIDTH-1:0]    d_rdata_o,
  // memory port
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [3:0]               mem_be_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_SAT = 4'hF;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_IF      = 2'd1,
    OWN_D_LOAD  = 2'd2,
    OWN_D_STORE = 2'd3
  } owner_t;

  owner_t           r_owner;
  logic [CNT_W-1:0] r_wait_cnt;

  logic w_if_forced;
  logic w_if_gnt;
  logic w_d_gnt;

  // Address bits above the decoded range and the byte offset are dropped.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0,
                         if_addr_i[DATA_WIDTH-1:ADDRESS_WIDTH], if_addr_i[1:0],
                         d_addr_i[DATA_WIDTH-1:ADDRESS_WIDTH],  d_addr_i[1:0]};

  assign w_if_forced = (r_wait_cnt >= CNT_W'(MAX_WAIT));

  // Grant decision: D preferred unless IF has waited too long; flush blocks IF.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (rst_n) begin
      if (if_req_i && !if_flush_i && (!d_req_i || w_if_forced)) begin
        w_if_gnt = 1'b1;
      end else if (d_req_i) begin
        w_d_gnt = 1'b1;
      end
    end
  end

  // Memory request and grant outputs for the winning port.
  always_comb begin
    if_gnt_o    = w_if_gnt;
    d_gnt_o     = w_d_gnt;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = '0;
    if (w_if_gnt) begin
      mem_en_o   = 1'b1;
      mem_addr_o = {if_addr_i[ADDRESS_WIDTH-1:2], 2'b00};
    end else if (w_d_gnt) begin
      mem_en_o   = 1'b1;
      mem_we_o   = d_we_i;
      mem_addr_o = {d_addr_i[ADDRESS_WIDTH-1:2], 2'b00};
      if (d_we_i) begin
        mem_be_o    = d_be_i;
        mem_wdata_o = d_wdata_i;
      end
    end
  end

  // Route the response to whoever owned last cycle's access.
  always_comb begin
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    if (rst_n) begin
      unique case (r_owner)
        OWN_IF: begin
          if (!if_flush_i) begin
            if_rvalid_o = 1'b1;
            if_rdata_o  = mem_rdata_i;
          end
        end
        OWN_D_LOAD: begin
          d_rvalid_o = 1'b1;
          d_rdata_o  = mem_rdata_i;
        end
        OWN_D_STORE: begin
          d_rvalid_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Response owner and IF starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner    <= OWN_NONE;
      r_wait_cnt <= '0;
    end else begin
      if (w_if_gnt) begin
        r_owner <= OWN_IF;
      end else if (w_d_gnt) begin
        r_owner <= d_we_i ? OWN_D_STORE : OWN_D_LOAD;
      end else begin
        r_owner <= OWN_NONE;
      end

      if (if_req_i && !w_if_gnt) begin
        r_wait_cnt <= (r_wait_cnt == CNT_SAT) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

endmodule
